// File: rtl/srs_symb_sched_pkg.sv
// Shared types and helpers for the per-slot SRS symbol scheduler.
package srs_symb_sched_pkg;

    localparam int unsigned LAST_SYMB_DEF = 13;
    localparam int unsigned SYMB_W        = 4;
    localparam int unsigned IDX_W         = 2;
    localparam int unsigned SLOT_W        = 5;
    localparam int unsigned CNT_W         = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_SYM,
        ST_GEN,
        ST_FFT
    } state_e;

    // Symbol-count code to number of SRS symbols; 0 marks the illegal code.
    function automatic logic [CNT_W-1:0] symb_num_decode(input logic [1:0] code);
        case (code)
            2'b00:   return CNT_W'(1);
            2'b01:   return CNT_W'(2);
            2'b11:   return CNT_W'(4);
            default: return CNT_W'(0);
        endcase
    endfunction

endpackage

// File: rtl/srs_symb_sched.sv
// Per-slot SRS symbol scheduler: fires one SRS generation + IFFT per allocated
// symbol on its symbol tick, with deadline and watchdog supervision.
module srs_symb_sched
    import srs_symb_sched_pkg::*;
#(
    parameter int unsigned TO_W      = 12,
    parameter int unsigned LAST_SYMB = LAST_SYMB_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              slot_start,
    input  logic [SLOT_W-1:0] n_slot_in,
    input  logic [1:0]        cfg_symb_num,
    input  logic [SYMB_W-1:0] cfg_start_symb,
    input  logic              symb_tick,
    input  logic [SYMB_W-1:0] symb_cnt,
    output logic              srs_start,
    output logic [IDX_W-1:0]  srs_symb_index,
    output logic [SLOT_W-1:0] srs_n_slot,
    input  logic              srs_done,
    output logic              ifft_start,
    input  logic              ifft_done,
    output logic              busy,
    output logic              done,
    output logic              err_cfg,
    output logic              err_ovr,
    output logic              err_to
);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SYMB_W-1:0]   start_symb_q, start_symb_d;
    logic [SLOT_W-1:0]   n_slot_q, n_slot_d;
    logic [IDX_W-1:0]    symb_index_q, symb_index_d;
    logic [TO_W-1:0]     wd_q, wd_d;
    logic                busy_q, busy_d;
    logic                srs_start_q, srs_start_d;
    logic                ifft_start_q, ifft_start_d;
    logic                done_q, done_d;
    logic                err_cfg_q, err_cfg_d;
    logic                err_ovr_q, err_ovr_d;
    logic                err_to_q, err_to_d;

    logic [CNT_W-1:0]    cfg_cnt_c;
    logic [SLOT_W-1:0]   cfg_last_c;
    logic                cfg_legal_c;
    logic                symb_match_c;
    logic                last_symb_c;

    // Legality uses a 5-bit sum so a start near the slot end cannot wrap.
    assign cfg_cnt_c    = symb_num_decode(cfg_symb_num);
    assign cfg_last_c   = SLOT_W'(cfg_start_symb) + SLOT_W'(cfg_cnt_c) - SLOT_W'(1);
    assign cfg_legal_c  = (cfg_cnt_c != '0) && (cfg_last_c <= SLOT_W'(LAST_SYMB));
    assign symb_match_c = symb_tick && (symb_cnt == SYMB_W'(start_symb_q + SYMB_W'(idx_q)));
    assign last_symb_c  = (idx_q == IDX_W'(cnt_q - CNT_W'(1)));

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        start_symb_d = start_symb_q;
        n_slot_d     = n_slot_q;
        symb_index_d = symb_index_q;
        wd_d         = wd_q;
        busy_d       = busy_q;
        srs_start_d  = 1'b0;
        ifft_start_d = 1'b0;
        done_d       = 1'b0;
        err_cfg_d    = 1'b0;
        err_ovr_d    = 1'b0;
        err_to_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (slot_start) begin
                    if (cfg_legal_c) begin
                        cnt_d        = cfg_cnt_c;
                        start_symb_d = cfg_start_symb;
                        n_slot_d     = n_slot_in;
                        idx_d        = '0;
                        busy_d       = 1'b1;
                        state_d      = ST_WAIT_SYM;
                    end else begin
                        err_cfg_d = 1'b1;
                    end
                end
            end
            ST_WAIT_SYM: begin
                if (slot_start) begin
                    err_ovr_d = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = ST_IDLE;
                end else if (symb_match_c) begin
                    srs_start_d  = 1'b1;
                    symb_index_d = idx_q;
                    wd_d         = '0;
                    state_d      = ST_GEN;
                end
            end
            ST_GEN: begin
                if (slot_start || symb_tick) begin
                    err_ovr_d = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = ST_IDLE;
                end else if (srs_done) begin
                    ifft_start_d = 1'b1;
                    wd_d         = '0;
                    state_d      = ST_FFT;
                end else if (&wd_q) begin
                    err_to_d = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = ST_IDLE;
                end else begin
                    wd_d = wd_q + TO_W'(1);
                end
            end
            ST_FFT: begin
                // A completion in the same cycle as the next tick still counts.
                if (slot_start) begin
                    err_ovr_d = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = ST_IDLE;
                end else if (ifft_done) begin
                    if (last_symb_c) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = ST_WAIT_SYM;
                    end
                end else if (symb_tick) begin
                    err_ovr_d = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = ST_IDLE;
                end else if (&wd_q) begin
                    err_to_d = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = ST_IDLE;
                end else begin
                    wd_d = wd_q + TO_W'(1);
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            start_symb_q <= '0;
            n_slot_q     <= '0;
            symb_index_q <= '0;
            wd_q         <= '0;
            busy_q       <= 1'b0;
            srs_start_q  <= 1'b0;
            ifft_start_q <= 1'b0;
            done_q       <= 1'b0;
            err_cfg_q    <= 1'b0;
            err_ovr_q    <= 1'b0;
            err_to_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            start_symb_q <= start_symb_d;
            n_slot_q     <= n_slot_d;
            symb_index_q <= symb_index_d;
            wd_q         <= wd_d;
            busy_q       <= busy_d;
            srs_start_q  <= srs_start_d;
            ifft_start_q <= ifft_start_d;
            done_q       <= done_d;
            err_cfg_q    <= err_cfg_d;
            err_ovr_q    <= err_ovr_d;
            err_to_q     <= err_to_d;
        end
    end

    assign srs_start      = srs_start_q;
    assign srs_symb_index = symb_index_q;
    assign srs_n_slot     = n_slot_q;
    assign ifft_start     = ifft_start_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err_cfg        = err_cfg_q;
    assign err_ovr        = err_ovr_q;
    assign err_to         = err_to_q;

endmodule

// File: tb/tb_srs_symb_sched.sv
// Bench for srs_symb_sched: table of slot scenarios, randomized slots against a
// slot-level model, and hand sequences for watchdog, overlap and reset.
module tb_srs_symb_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       slot_start;
    logic [4:0] n_slot_in;
    logic [1:0] cfg_symb_num;
    logic [3:0] cfg_start_symb;
    logic       symb_tick;
    logic [3:0] symb_cnt;
    logic       srs_start;
    logic [1:0] srs_symb_index;
    logic [4:0] srs_n_slot;
    logic       srs_done;
    logic       ifft_start;
    logic       ifft_done;
    logic       busy;
    logic       done;
    logic       err_cfg;
    logic       err_ovr;
    logic       err_to;

    int errors = 0;
    int checks = 0;

    srs_symb_sched #(.TO_W(4), .LAST_SYMB(13)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .slot_start     (slot_start),
        .n_slot_in      (n_slot_in),
        .cfg_symb_num   (cfg_symb_num),
        .cfg_start_symb (cfg_start_symb),
        .symb_tick      (symb_tick),
        .symb_cnt       (symb_cnt),
        .srs_start      (srs_start),
        .srs_symb_index (srs_symb_index),
        .srs_n_slot     (srs_n_slot),
        .srs_done       (srs_done),
        .ifft_start     (ifft_start),
        .ifft_done      (ifft_done),
        .busy           (busy),
        .done           (done),
        .err_cfg        (err_cfg),
        .err_ovr        (err_ovr),
        .err_to         (err_to)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] num;
        logic [3:0] st;
        logic [4:0] ns;
        int         late;
        int         es;
        int         ed;
        int         ec;
        int         eo;
        int         et;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Slot-level expectation: which symbols get generated and how the slot ends.
    // A withheld IFFT is caught by the next symbol tick, or by the watchdog
    // when it was the last symbol of the slot.
    task automatic model(input logic [1:0] num, input logic [3:0] st, input int late,
                         output int es, output int ed, output int ec,
                         output int eo, output int et);
        int n;
        n  = (num == 2'b00) ? 1 : (num == 2'b01) ? 2 : (num == 2'b11) ? 4 : 0;
        es = 0; ed = 0; ec = 0; eo = 0; et = 0;
        if (n == 0 || int'(st) + n - 1 > 13) begin
            ec = 1;
        end else if (late < n) begin
            es = late + 1;
            if (int'(st) + late == 13) et = 1;
            else                       eo = 1;
        end else begin
            es = n;
            ed = 1;
        end
    endtask

    // Drives one slot with ticks for symbols 0..13 and an srs/ifft responder;
    // the IFFT of symbol index 'late' is never completed.
    task automatic run_slot(input vec_t v);
        int n_start = 0;
        int n_done = 0;
        int n_cfg = 0;
        int n_ovr = 0;
        int n_to = 0;
        int prev_tick = -1;
        bit srs_pend = 0;
        bit ifft_pend = 0;
        slot_start     = 1'b1;
        cfg_symb_num   = v.num;
        cfg_start_symb = v.st;
        n_slot_in      = v.ns;
        @(negedge clk);
        for (int c = 0; c < 14 * 12 + 40; c++) begin
            if (c == 0) chk("busy_after_slot_start", int'(busy), (v.ec == 0) ? 1 : 0);
            if (srs_start) begin
                chk("srs_start_tick", prev_tick, int'(v.st) + n_start);
                chk("srs_symb_index", int'(srs_symb_index), n_start % 4);
                chk("srs_n_slot", int'(srs_n_slot), int'(v.ns));
                n_start++;
                srs_pend = 1;
            end
            if (ifft_start && (n_start - 1) != v.late) ifft_pend = 1;
            if (done)    n_done++;
            if (err_cfg) n_cfg++;
            if (err_ovr) n_ovr++;
            if (err_to)  n_to++;
            slot_start = 1'b0;
            srs_done   = srs_pend;
            ifft_done  = ifft_pend;
            srs_pend   = 0;
            ifft_pend  = 0;
            if (c % 12 == 3 && c / 12 <= 13) begin
                symb_tick = 1'b1;
                symb_cnt  = 4'(c / 12);
                prev_tick = c / 12;
            end else begin
                symb_tick = 1'b0;
                prev_tick = -1;
            end
            @(negedge clk);
        end
        chk("slot_srs_starts", n_start, v.es);
        chk("slot_done", n_done, v.ed);
        chk("slot_err_cfg", n_cfg, v.ec);
        chk("slot_err_ovr", n_ovr, v.eo);
        chk("slot_err_to", n_to, v.et);
        chk("slot_end_busy", int'(busy), 0);
    endtask

    function automatic int out_vec();
        return int'({srs_start, srs_symb_index, srs_n_slot, ifft_start,
                     busy, done, err_cfg, err_ovr, err_to});
    endfunction

    initial begin
        vec_t v;
        int   n;
        tbl[0]  = '{2'b00, 4'd12, 5'd7,  4, 1, 1, 0, 0, 0};
        tbl[1]  = '{2'b11, 4'd8,  5'd3,  4, 4, 1, 0, 0, 0};
        tbl[2]  = '{2'b10, 4'd0,  5'd1,  4, 0, 0, 1, 0, 0};
        tbl[3]  = '{2'b11, 4'd12, 5'd2,  4, 0, 0, 1, 0, 0};
        tbl[4]  = '{2'b01, 4'd4,  5'd2,  0, 1, 0, 0, 1, 0};
        tbl[5]  = '{2'b11, 4'd10, 5'd31, 4, 4, 1, 0, 0, 0};
        tbl[6]  = '{2'b01, 4'd13, 5'd6,  4, 0, 0, 1, 0, 0};
        tbl[7]  = '{2'b00, 4'd13, 5'd5,  0, 1, 0, 0, 0, 1};
        tbl[8]  = '{2'b11, 4'd0,  5'd0,  2, 3, 0, 0, 1, 0};
        tbl[9]  = '{2'b00, 4'd15, 5'd9,  4, 0, 0, 1, 0, 0};
        tbl[10] = '{2'b01, 4'd12, 5'd20, 4, 2, 1, 0, 0, 0};

        rst_n = 1'b0;
        slot_start = 1'b0; n_slot_in = '0; cfg_symb_num = '0; cfg_start_symb = '0;
        symb_tick = 1'b0; symb_cnt = '0; srs_done = 1'b0; ifft_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", out_vec(), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_outputs", out_vec(), 0);

        for (int i = 0; i < 11; i++) run_slot(tbl[i]);

        // Watchdog: srs_done never arrives.
        slot_start = 1'b1; cfg_symb_num = 2'b00; cfg_start_symb = 4'd2; n_slot_in = 5'd4;
        @(negedge clk);
        slot_start = 1'b0; symb_tick = 1'b1; symb_cnt = 4'd2;
        @(negedge clk);
        symb_tick = 1'b0;
        chk("wd_srs_start", int'(srs_start), 1);
        n = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (err_to) begin
                n = k;
                break;
            end
        end
        chk("wd_timeout_in_window", int'(n >= 15 && n <= 17), 1);
        chk("wd_busy_cleared", int'(busy), 0);
        run_slot(tbl[0]);

        // slot_start while busy aborts and is itself ignored.
        slot_start = 1'b1; cfg_symb_num = 2'b01; cfg_start_symb = 4'd3; n_slot_in = 5'd9;
        @(negedge clk);
        slot_start = 1'b0;
        chk("ovl_busy", int'(busy), 1);
        @(negedge clk);
        slot_start = 1'b1;
        @(negedge clk);
        slot_start = 1'b0;
        chk("ovl_err_ovr", int'(err_ovr), 1);
        chk("ovl_busy_dropped", int'(busy), 0);
        symb_tick = 1'b1; symb_cnt = 4'd3;
        @(negedge clk);
        symb_tick = 1'b0;
        chk("ovl_new_slot_ignored", int'(busy), 0);
        chk("ovl_err_single", int'(err_ovr), 0);
        @(negedge clk);
        chk("ovl_no_srs_start", int'(srs_start), 0);
        run_slot(tbl[1]);

        // Reset while the IFFT is outstanding.
        slot_start = 1'b1; cfg_symb_num = 2'b00; cfg_start_symb = 4'd1; n_slot_in = 5'd17;
        @(negedge clk);
        slot_start = 1'b0; symb_tick = 1'b1; symb_cnt = 4'd1;
        @(negedge clk);
        symb_tick = 1'b0;
        chk("rst_seq_srs_start", int'(srs_start), 1);
        srs_done = 1'b1;
        @(negedge clk);
        srs_done = 1'b0;
        chk("rst_seq_ifft_start", int'(ifft_start), 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_outputs", out_vec(), 0);
        rst_n = 1'b1;
        ifft_done = 1'b1;
        @(negedge clk);
        ifft_done = 1'b0;
        chk("rst_stray_ifft_ignored", int'({done, busy}), 0);
        run_slot(tbl[5]);

        for (int r = 0; r < 25; r++) begin
            v.num  = 2'($urandom_range(0, 3));
            v.st   = 4'($urandom_range(0, 15));
            v.ns   = 5'($urandom_range(0, 31));
            v.late = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : 4;
            model(v.num, v.st, v.late, v.es, v.ed, v.ec, v.eo, v.et);
            run_slot(v);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
